// File: rtl/alu_pkg.sv
// Shared opcode encodings and entry field widths for the ALU result path.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int unsigned DW_DEFAULT = 5;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned FLAGS_W    = 3;

  // {equal, greater, lesser} must have exactly one bit set for a sane compare.
  function automatic logic is_onehot3(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Opcode-driven result select, flag packing and compare-flag sanity check.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic               select0,
  input  logic               select1,
  input  logic [DW-1:0]      result1,
  input  logic [DW-1:0]      result2,
  input  logic [DW-1:0]      result4,
  input  logic               equal,
  input  logic               greater,
  input  logic               lesser,
  output logic [DW-1:0]      payload,
  output logic [OP_W-1:0]    op,
  output logic [FLAGS_W-1:0] flags,
  output logic               cmp_bad
);

  always_comb begin
    op      = {select1, select0};
    flags   = {equal, greater, lesser};
    payload = '0;
    case (op)
      OP_ADD:  payload = result1;
      OP_SUB:  payload = result2;
      OP_CMP:  payload[FLAGS_W-1:0] = flags;
      OP_AND:  payload = result4;
      default: payload = '0;
    endcase
    cmp_bad = (op == OP_CMP) && !is_onehot3(flags);
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Tagged ALU result FIFO with valid/ready hand-off to the consumer stage.
// Optional per-entry even parity output enabled by defining ALU_RES_PARITY_EN.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   select0,
  input  logic                   select1,
  input  logic [DW-1:0]          result1,
  input  logic [DW-1:0]          result2,
  input  logic [DW-1:0]          result4,
  input  logic                   equal,
  input  logic                   greater,
  input  logic                   lesser,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [OP_W-1:0]        out_op,
  output logic [FLAGS_W-1:0]     out_flags,
  output logic [$clog2(DEPTH):0] count,
`ifdef ALU_RES_PARITY_EN
  output logic                   out_parity,
`endif
  output logic                   cmp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = DW + OP_W + FLAGS_W;
`ifdef ALU_RES_PARITY_EN
  localparam int unsigned EW = BW + 1;
`else
  localparam int unsigned EW = BW;
`endif
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [DW-1:0]      payload;
  logic [OP_W-1:0]    op;
  logic [FLAGS_W-1:0] flags;
  logic               cmp_bad;
  logic               push;
  logic               pop;
  logic [EW-1:0]      wentry;
  logic [EW-1:0]      head;

  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [AW:0]        count_q;
  logic               cmp_err_q;
  logic [EW-1:0]      mem_q [DEPTH];

  alu_result_mux #(
    .DW (DW)
  ) u_mux (
    .select0 (select0),
    .select1 (select1),
    .result1 (result1),
    .result2 (result2),
    .result4 (result4),
    .equal   (equal),
    .greater (greater),
    .lesser  (lesser),
    .payload (payload),
    .op      (op),
    .flags   (flags),
    .cmp_bad (cmp_bad)
  );

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef ALU_RES_PARITY_EN
  assign wentry = {^{payload, op, flags}, payload, op, flags};
`else
  assign wentry = {payload, op, flags};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      cmp_err_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push && cmp_bad) cmp_err_q <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wentry;
  end

  assign head = mem_q[rptr_q];
  assign {out_data, out_op, out_flags} = out_valid ? head[BW-1:0] : '0;
`ifdef ALU_RES_PARITY_EN
  assign out_parity = out_valid ? head[EW-1] : 1'b0;
`endif
  assign count   = count_q;
  assign cmp_err = cmp_err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomised self-checking bench for alu_result_buffer against a queue model.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0] data;
    logic [1:0] op;
    logic [2:0] flags;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic       select0, select1;
  logic [4:0] result1, result2, result4;
  logic       equal, greater, lesser;
  logic       out_valid, out_ready;
  logic [4:0] out_data;
  logic [1:0] out_op;
  logic [2:0] out_flags;
  logic [2:0] count;
  logic       cmp_err;
`ifdef ALU_RES_PARITY_EN
  logic       out_parity;
`endif

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  bit   merr;

  always #5 clk = ~clk;

  alu_result_buffer #(
    .DEPTH (DEPTH),
    .DW    (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .select0    (select0),
    .select1    (select1),
    .result1    (result1),
    .result2    (result2),
    .result4    (result4),
    .equal      (equal),
    .greater    (greater),
    .lesser     (lesser),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_flags  (out_flags),
    .count      (count),
`ifdef ALU_RES_PARITY_EN
    .out_parity (out_parity),
`endif
    .cmp_err    (cmp_err)
  );

  // What the buffer should store for the inputs currently presented.
  function automatic ent_t cur_entry();
    ent_t e;
    e.op    = {select1, select0};
    e.flags = {equal, greater, lesser};
    case (e.op)
      2'b00:   e.data = result1;
      2'b01:   e.data = result2;
      2'b10:   e.data = {2'b00, e.flags};
      default: e.data = result4;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] d,
                       input logic [2:0] f);
    in_valid = v;
    {select1, select0} = op;
    result1 = 5'($urandom);
    result2 = 5'($urandom);
    result4 = 5'($urandom);
    {equal, greater, lesser} = f;
    case (op)
      2'b00:   result1 = d;
      2'b01:   result2 = d;
      2'b11:   result4 = d;
      default: ;
    endcase
  endtask

  // Advance one clock, updating the model from the pre-edge handshake.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    push = in_valid && (mq.size() != DEPTH);
    pop  = out_ready && (mq.size() != 0);
    e    = cur_entry();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        if (e.op == 2'b10 && $countones(e.flags) != 1) merr = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 3'b000);
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({out_data, out_op, out_flags} !== 10'd0) begin
      errors++; $display("FAIL reset_out_fields got %h/%h/%h want 0", out_data, out_op, out_flags);
    end
    checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL reset_cmp_err got %b want 0", cmp_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 5'b10010, 3'b000);
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 5'b10010 || out_op !== 2'b00) begin
      errors++; $display("FAIL add_visible got v=%b d=%b op=%b want v=1 d=10010 op=00",
                         out_valid, out_data, out_op);
    end
    cycle();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL add_popped got count=%0d v=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [1:0] ops   [4];
    logic [4:0] datas [4];
    logic [2:0] flgs  [4];
    logic [4:0] exp_d [4];
    ops   = '{2'b01, 2'b10, 2'b11, 2'b00};
    datas = '{5'b01000, 5'b00000, 5'b00000, 5'b00001};
    flgs  = '{3'b010, 3'b001, 3'b100, 3'b000};
    exp_d = '{5'b01000, 5'b00001, 5'b00000, 5'b00001};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], datas[i], flgs[i]);
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full got count=%0d rdy=%b want 4/0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_op !== ops[i]) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%b op=%b want 1/%b/%b",
                           i, out_valid, out_data, out_op, exp_d[i], ops[i]);
      end
      if (i == 1) begin
        checks++; if (out_flags !== 3'b001) begin
          errors++; $display("FAIL drain_cmp_flags got %b want 001", out_flags);
        end
      end
      cycle();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_empty got %0d want 0", count); end
  endtask

  task automatic test_full_pushpop();
    ent_t h;
    drain();
    out_ready = 1'b0;
    repeat (DEPTH) begin
      drive(1'b1, 2'($urandom), 5'($urandom), 3'($urandom));
      cycle();
    end
    drive(1'b1, 2'b11, 5'($urandom), 3'b000);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_before got count=%0d rdy=%b want 4/0", count, in_ready);
    end
    out_ready = 1'b1;
    cycle();
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop got count=%0d rdy=%b want 3/1", count, in_ready);
    end
    cycle();
    h = mq[0];
    checks++; if (count !== 3'd3 || out_data !== h.data || out_op !== h.op) begin
      errors++; $display("FAIL full_pushpop got count=%0d d=%b op=%b want 3/%b/%b",
                         count, out_data, out_op, h.data, h.op);
    end
  endtask

  task automatic test_random();
    ent_t h;
    for (int c = 0; c < 60; c++) begin
      // Upstream holds its offer until it is accepted.
      if (!(in_valid && mq.size() == DEPTH)) begin
        drive(1'($urandom), 2'($urandom), 5'($urandom), 3'($urandom));
      end
      out_ready = 1'($urandom);
      cycle();
      checks++; if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
                    in_ready !== (mq.size() != DEPTH) || cmp_err !== merr) begin
        errors++; $display("FAIL rand_ctrl_%0d got cnt=%0d v=%b r=%b e=%b want cnt=%0d e=%b",
                           c, count, out_valid, in_ready, cmp_err, mq.size(), merr);
      end
      if (mq.size() != 0) begin
        h = mq[0];
        checks++; if (out_data !== h.data || out_op !== h.op || out_flags !== h.flags) begin
          errors++; $display("FAIL rand_head_%0d got %b/%b/%b want %b/%b/%b", c,
                             out_data, out_op, out_flags, h.data, h.op, h.flags);
        end
      end
    end
  endtask

  task automatic test_cmp_err();
    rst = 1'b1;
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 5'd3, 3'b111);
    cycle();
    checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL cmp_err_add got %b want 0", cmp_err); end
    drive(1'b1, 2'b10, 5'd0, 3'b000);
    cycle();
    checks++; if (cmp_err !== 1'b1) begin errors++; $display("FAIL cmp_err_000 got %b want 1", cmp_err); end
    drive(1'b1, 2'b10, 5'd0, 3'b110);
    cycle();
    checks++; if (cmp_err !== 1'b1) begin errors++; $display("FAIL cmp_err_110 got %b want 1", cmp_err); end
    drive(1'b1, 2'b10, 5'd0, 3'b010);
    cycle();
    checks++; if (cmp_err !== 1'b1) begin errors++; $display("FAIL cmp_err_sticky got %b want 1", cmp_err); end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL cmp_err_rst got %b want 0", cmp_err); end
  endtask

  task automatic test_reset_mid();
    drain();
    out_ready = 1'b0;
    repeat (3) begin
      drive(1'b1, 2'b11, 5'($urandom_range(1, 31)), 3'b000);
      cycle();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 5'd0) begin
      errors++; $display("FAIL mid_rst got cnt=%0d v=%b d=%b want 0/0/0", count, out_valid, out_data);
    end
    drive(1'b1, 2'b11, 5'b00101, 3'b000);
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 5'b00101 || out_op !== 2'b11) begin
      errors++; $display("FAIL mid_after got v=%b d=%b op=%b want 1/00101/11", out_valid, out_data, out_op);
    end
  endtask

`ifdef ALU_RES_PARITY_EN
  task automatic test_parity();
    logic [1:0] ops   [3];
    logic [4:0] datas [3];
    logic [2:0] flgs  [3];
    ent_t       h;
    ops   = '{2'b00, 2'b01, 2'b10};
    datas = '{5'b10010, 5'b10011, 5'b00000};
    flgs  = '{3'b000, 3'b000, 3'b001};
    drain();
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      drive(1'b1, ops[i], datas[i], flgs[i]);
      cycle();
      in_valid = 1'b0;
      h = mq[0];
      checks++; if (out_parity !== ^{h.data, h.op, h.flags}) begin
        errors++; $display("FAIL parity_%0d got %b want %b", i, out_parity, ^{h.data, h.op, h.flags});
      end
      out_ready = 1'b1;
      cycle();
    end
  endtask
`endif

  initial begin
    merr = 1'b0;
    test_reset();
    test_single_add();
    test_fill_drain();
    test_full_pushpop();
    test_random();
    test_cmp_err();
    test_reset_mid();
`ifdef ALU_RES_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
